// File: rtl/count_disp_pkg.sv
// Shared types and constants for the BCD display converter: FSM states, widths,
// seven-segment patterns and the double-dabble nibble adjust.
package count_disp_pkg;

  localparam int unsigned COUNT_W = 8;
  localparam int unsigned BCD_W   = 12;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Pre-shift correction so a nibble carries correctly into the next decade.
  function automatic logic [3:0] add3_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/count_bcd_display_if.sv
// Request/result bundle between the surrounding logic (master) and the converter (slave).
interface count_bcd_display_if;
  import count_disp_pkg::*;

  logic               en;
  logic [COUNT_W-1:0] count_in;
  logic               busy;
  logic               done;
  logic [3:0]         bcd_hund;
  logic [3:0]         bcd_tens;
  logic [3:0]         bcd_ones;
  logic [6:0]         seg_hund;
  logic [6:0]         seg_tens;
  logic [6:0]         seg_ones;

  modport master (
    output en, count_in,
    input  busy, done, bcd_hund, bcd_tens, bcd_ones, seg_hund, seg_tens, seg_ones
  );

  modport slave (
    input  en, count_in,
    output busy, done, bcd_hund, bcd_tens, bcd_ones, seg_hund, seg_tens, seg_ones
  );

endinterface

// File: rtl/seg7_decode.sv
// BCD nibble to seven-segment pattern; non-decimal nibbles blank the digit.
module seg7_decode
  import count_disp_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  logic [6:0] pattern;

  always_comb begin
    pattern = SEG_BLANK;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    seg = SEG_ACTIVE_LOW ? ~pattern : pattern;
  end

endmodule

// File: rtl/count_bcd_display.sv
// Samples an 8-bit count on request, converts it to three BCD digits with a
// sequential double-dabble engine and drives three seven-segment patterns.
module count_bcd_display
  import count_disp_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  count_bcd_display_if.slave  bus
);

  state_e             state_q;
  logic [COUNT_W-1:0] shift_q;
  logic [BCD_W-1:0]   scratch_q;
  logic [2:0]         bitcnt_q;
  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W+COUNT_W-1:0] shifted;

  // All nibbles are adjusted from their pre-adjust values, then the whole chain shifts.
  assign scratch_adj = {add3_adjust(scratch_q[11:8]), add3_adjust(scratch_q[7:4]),
                        add3_adjust(scratch_q[3:0])};
  assign shifted     = {scratch_adj, shift_q} << 1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      scratch_q    <= '0;
      bitcnt_q     <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.bcd_hund <= '0;
      bus.bcd_tens <= '0;
      bus.bcd_ones <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.en) begin
            shift_q   <= bus.count_in;
            scratch_q <= '0;
            bitcnt_q  <= '0;
            bus.busy  <= 1'b1;
            state_q   <= StShift;
          end
        end
        StShift: begin
          {scratch_q, shift_q} <= shifted;
          bitcnt_q             <= bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          {bus.bcd_hund, bus.bcd_tens, bus.bcd_ones} <= scratch_q;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  seg7_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_hund (
    .digit (bus.bcd_hund),
    .seg   (bus.seg_hund)
  );

  seg7_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_tens (
    .digit (bus.bcd_tens),
    .seg   (bus.seg_tens)
  );

  seg7_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_ones (
    .digit (bus.bcd_ones),
    .seg   (bus.seg_ones)
  );

endmodule

// File: tb/tb_count_bcd_display.sv
// Directed and random checks of count_bcd_display against an arithmetic reference
// (div/mod by 10) and a segment lookup table; a second, active-low copy tracks the first.
module tb_count_bcd_display;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  count_bcd_display_if bus ();
  count_bcd_display_if bus_n ();

  count_bcd_display #(.SEG_ACTIVE_LOW(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  count_bcd_display #(.SEG_ACTIVE_LOW(1'b1)) dut_n (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_n)
  );

  assign bus_n.en       = bus.en;
  assign bus_n.count_in = bus.count_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input int v, input string tag);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    chk({tag, " hund"}, bus.bcd_hund, h);
    chk({tag, " tens"}, bus.bcd_tens, t);
    chk({tag, " ones"}, bus.bcd_ones, o);
    chk({tag, " seg_hund"}, bus.seg_hund, seg_tab[h]);
    chk({tag, " seg_tens"}, bus.seg_tens, seg_tab[t]);
    chk({tag, " seg_ones"}, bus.seg_ones, seg_tab[o]);
    chk({tag, " segn_hund"}, bus_n.seg_hund, 7'h7F & ~seg_tab[h]);
    chk({tag, " segn_ones"}, bus_n.seg_ones, 7'h7F & ~seg_tab[o]);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " busy"}, bus.busy, 0);
    chk({tag, " done"}, bus.done, 0);
    chk({tag, " bcd"}, {bus.bcd_hund, bus.bcd_tens, bus.bcd_ones}, 0);
    chk({tag, " seg"}, {bus.seg_hund, bus.seg_tens, bus.seg_ones}, {3{7'h3F}});
    chk({tag, " segn"}, {bus_n.seg_hund, bus_n.seg_tens, bus_n.seg_ones}, {3{7'h40}});
  endtask

  // Capture v with a one-cycle request; result must appear exactly 9 edges later.
  task automatic convert(input int v, input string tag);
    bus.count_in = 8'(v);
    bus.en       = 1'b1;
    tick();
    bus.en = 1'b0;
    chk({tag, " busy after capture"}, bus.busy, 1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk({tag, " early done"}, bus.done, 0);
    end
    tick();
    chk({tag, " done"}, bus.done, 1);
    chk({tag, " busy at done"}, bus.busy, 0);
    check_result(v, tag);
    tick();
    chk({tag, " done cleared"}, bus.done, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset        = 1'b0;
    bus.en       = 1'b0;
    bus.count_in = '0;
    #12;
    check_reset_state("reset");
    tick();
    reset = 1'b1;
    tick();
    check_reset_state("idle after reset");

    convert(255, "c255");
    chk("c255 seg_hund lit", bus.seg_hund, 7'b1011011);
    chk("c255 seg_ones lit", bus.seg_ones, 7'b1101101);

    foreach (seg_tab[i]) begin end
    convert(0, "c0");
    convert(9, "c9");
    convert(10, "c10");
    convert(99, "c99");
    convert(100, "c100");
    convert(128, "c128");
    chk("c128 seg_ones eight", bus.seg_ones, 7'b1111111);
    convert(199, "c199");
    repeat (16) convert(int'($urandom_range(0, 255)), "rand");

    // Input and request changes during a conversion are ignored.
    bus.count_in = 8'd37;
    bus.en       = 1'b1;
    tick();
    bus.en = 1'b0;
    tick();
    bus.count_in = 8'd200;
    bus.en       = 1'b1;
    tick();
    bus.en = 1'b0;
    for (int k = 3; k <= 8; k++) begin
      tick();
      chk("ign early done", bus.done, 0);
    end
    tick();
    chk("ign done", bus.done, 1);
    check_result(37, "ign");
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("ign no second done", bus.done, 0);
      chk("ign no second busy", bus.busy, 0);
    end

    // Asynchronous reset during a conversion of 200.
    bus.count_in = 8'd200;
    bus.en       = 1'b1;
    tick();
    bus.en = 1'b0;
    tick();
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("mid reset");
    tick();
    chk("mid reset held done", bus.done, 0);
    bus.count_in = 8'd45;
    bus.en       = 1'b1;
    reset        = 1'b1;
    tick();
    bus.en = 1'b0;
    chk("post reset capture busy", bus.busy, 1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("post reset early done", bus.done, 0);
    end
    tick();
    chk("post reset done", bus.done, 1);
    check_result(45, "post reset");
    tick();

    // Back-to-back conversions with the request held high.
    bus.count_in = 8'd0;
    bus.en       = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      bus.count_in = 8'(i + 1);
      if (i == 5) bus.en = 1'b0;
      for (int k = 1; k <= 10; k++) begin
        tick();
        if (k == 9) begin
          chk("b2b done", bus.done, 1);
          chk("b2b busy gap", bus.busy, 0);
          check_result(i, "b2b");
        end else if (k < 9 || i < 5) begin
          chk("b2b done idle", bus.done, 0);
          chk("b2b busy", bus.busy, 1);
        end else begin
          chk("b2b final idle", bus.busy, 0);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/count_bcd_display.md
# count_bcd_display

Downstream consumer of the 8-bit up/down counter's `count_out`. It samples the count on request and converts it to three BCD digits (hundreds/tens/ones) with a sequential shift-and-add-3 (double-dabble) engine. It then drives three seven-segment digit patterns for the lab display board. One conversion is in flight at a time; a `busy`/`done` pair tells the surrounding logic when results are valid.

## Interface
- `SEG_ACTIVE_LOW`, default 0: 0 = segment lit when bit is 1; 1 = all segment outputs inverted (common-anode board).
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low; `reset`=0 forces every register to its reset value immediately.
- `en`  in  1  conversion request; sampled only in IDLE.
- `count_in`  in  8  unsigned count from the up/down counter (`count_out`).
- `busy`  out  1  high while a conversion is in progress (SHIFT or DONE).
- `done`  out  1  one-cycle pulse; BCD/segment outputs were updated this cycle.
- `bcd_hund`  out  4  hundreds digit, range 0–2.
- `bcd_tens`  out  4  tens digit, range 0–9.
- `bcd_ones`  out  4  ones digit, range 0–9.
- `seg_hund`, `seg_tens`, `seg_ones`  out  7 each  segment patterns, bit order {g,f,e,d,c,b,a}.

## Operation
- FSM states:
  - IDLE: `busy`=0. If `en`=1 at a rising edge:
    - capture `count_in` into an 8-bit shift register;
    - clear the 12-bit BCD scratch register;
    - set the bit counter to 0;
    - go to SHIFT.
  - SHIFT: `busy`=1. Each edge does two things:
    - for every scratch nibble ≥5, add 3 (all three nibbles are evaluated on pre-adjust values);
    - then shift {scratch, shift register} left by 1.
    - After the 8th shift (bit counter = 7), go to DONE.
  - DONE: `busy`=1. On the next edge:
    - copy scratch into `bcd_hund`/`bcd_tens`/`bcd_ones`;
    - set `done`=1;
    - return to IDLE.
- Arithmetic: the input is unsigned. Adjust-add operates on 4-bit nibbles with no carry between them. Max input 255 gives 2/5/5. `bcd_hund[3:2]` is always 0.
- Input stability:
  - `count_in` is sampled only at the capture edge.
  - Changes during SHIFT/DONE have no effect.
  - `en` is ignored outside IDLE; no request is queued.
- Outputs hold their last converted value indefinitely between conversions.
- Seven-segment patterns (active-high, {g..a}):
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111
  - Any other nibble = 0000000 (blank).
  - `SEG_ACTIVE_LOW`=1 inverts all seven bits.
- Segment outputs are combinational decodes of the registered BCD outputs.

## Timing
- Reset values:
  - state IDLE; `busy`=0; `done`=0;
  - all BCD outputs 0;
  - segment outputs = pattern for digit 0 (0111111, or 1000000 when active-low);
  - internal shift/scratch/counter registers 0.
- Cycle timeline, where E0 is the capture edge:
  - `busy` rises after E0.
  - Shifts occur at E1–E8.
  - DONE is entered after E8.
  - At E9: BCD registers update, `done`=1, `busy`=0.
  - At E10: `done` returns to 0.
- Latency: 9 clock edges from capture edge to valid result.
- Back-to-back: if `en` stays high, the next capture is at E10, which is also the edge that clears `done`. Throughput is therefore one conversion per 10 cycles.
- Reset mid-conversion:
  - Conversion is aborted; outputs return to reset values; no `done` pulse.
  - After `reset` deasserts, the first edge with `en`=1 starts a fresh capture.
- `en` and `reset` deassertion on the same edge: reset wins while low. The first rising edge with `reset`=1 may capture.

## Structure
- Package `count_disp_pkg`:
  - state enum (IDLE, SHIFT, DONE);
  - `COUNT_W` = 8, `BCD_W` = 12;
  - the ten segment-pattern constants and the blank constant.
- Sub-module `seg7_decode`: 4-bit nibble in, 7-bit pattern out, `SEG_ACTIVE_LOW` parameter passed through. Instantiated three times.
- The top level holds the FSM, bit counter, shift/scratch registers and output registers.

## Test plan
- Reset: `reset`=0 asserted mid-run → immediately `busy`=0, `done`=0, all BCD = 0, each seg = 0111111.
- `count_in`=255, one-cycle `en` → `done` pulse exactly 9 edges after capture with 2/5/5; `seg_hund`=1011011, `seg_tens`=`seg_ones`=1101101.
- Sweep `count_in` over 0, 9, 10, 99, 100, 128, 199:
  - each → correct digits (e.g. 128 → 1/2/8, 99 → 0/9/9);
  - `seg_ones` for 8 = 1111111.
- Capture 37, then drive `count_in`=200 and pulse `en` during SHIFT → result 0/3/7, exactly one `done`, no second conversion.
- `reset` low at E4 of a conversion of 200, then release with `en`=1 and `count_in`=45 → no `done` for 200; next result 0/4/5 after 9 edges.
- `en` held high with `count_in` stepping 0→1→2… → one `done` every 10 cycles, `busy` low exactly one cycle between conversions.
- `SEG_ACTIVE_LOW`=1 build, input 0 → all segments 1000000.
